// File: rtl/key_event_scheduler.sv
// Key press/release event scheduler: edge-detects N_KEYS level inputs, queues one pending
// event per key, and hands events out round-robin on a valid/ready port. Option: KEY_RELEASE_EVENT_EN.
module key_event_scheduler #(
    parameter int unsigned N_KEYS = 4,
    parameter int unsigned KEY_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KEY_W-1:0]  evt_key,
    output logic              evt_release,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned DROP_W = $clog2(2 * N_KEYS + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_KEYS-1:0]   key_d;
    logic [N_KEYS-1:0]   press_pend, press_pend_n;
    logic [N_KEYS-1:0]   press_edge, press_drop, grant_press;
    logic [N_KEYS-1:0]   req;
    logic [KEY_W-1:0]    ptr_q, ptr_d;
    logic [KEY_W-1:0]    evt_key_d;
    logic [KEY_W-1:0]    cand;
    logic [KEY_W-1:0]    grant_idx;
    logic                found;
    logic                do_load;
    logic                evt_valid_d;
    logic                busy_d;
    logic [DROP_W-1:0]   n_drop;
    logic [SUM_W-1:0]    drop_sum;
    logic [CNT_W-1:0]    drop_cnt_d;

`ifdef KEY_RELEASE_EVENT_EN
    logic [N_KEYS-1:0]   release_pend, release_pend_n;
    logic [N_KEYS-1:0]   release_edge, release_drop, grant_rel;
    logic                rel_q, rel_d;

    assign release_edge = ~key_in & key_d;
    assign req          = press_pend | release_pend;
    assign evt_release  = rel_q;
`else
    assign req          = press_pend;
    assign evt_release  = 1'b0;
`endif

    assign press_edge = key_in & ~key_d;
    assign do_load    = (state_q == EMPTY) || evt_ready;

    // Round-robin search starting one past the last granted key
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_KEYS; off++) begin
            cand = KEY_W'((32'(ptr_q) + off) % N_KEYS);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        evt_key_d   = evt_key;
        ptr_d       = ptr_q;
        grant_press = '0;
`ifdef KEY_RELEASE_EVENT_EN
        grant_rel   = '0;
        rel_d       = rel_q;
`endif
        if (do_load) begin
            if (found) begin
                state_d   = HOLD;
                evt_key_d = grant_idx;
                ptr_d     = grant_idx;
`ifdef KEY_RELEASE_EVENT_EN
                // Press takes precedence over release when both are pending
                if (press_pend[grant_idx]) begin
                    grant_press[grant_idx] = 1'b1;
                    rel_d                  = 1'b0;
                end else begin
                    grant_rel[grant_idx]   = 1'b1;
                    rel_d                  = 1'b1;
                end
`else
                grant_press[grant_idx] = 1'b1;
`endif
            end else begin
                state_d = EMPTY;
            end
        end
        evt_valid_d = (state_d == HOLD);

        // A bit being granted this edge can absorb a new edge without loss
        press_pend_n = (press_pend & ~grant_press) | press_edge;
        press_drop   = press_edge & press_pend & ~grant_press;
`ifdef KEY_RELEASE_EVENT_EN
        release_pend_n = (release_pend & ~grant_rel) | release_edge;
        release_drop   = release_edge & release_pend & ~grant_rel;
`endif

        n_drop = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            n_drop = n_drop + DROP_W'(press_drop[i]);
`ifdef KEY_RELEASE_EVENT_EN
            n_drop = n_drop + DROP_W'(release_drop[i]);
`endif
        end
        drop_sum   = SUM_W'(drop_cnt) + SUM_W'(n_drop);
        drop_cnt_d = (drop_sum > SUM_W'(255)) ? CNT_W'(255) : drop_sum[CNT_W-1:0];

`ifdef KEY_RELEASE_EVENT_EN
        busy_d = evt_valid_d | (|press_pend_n) | (|release_pend_n);
`else
        busy_d = evt_valid_d | (|press_pend_n);
`endif
    end

    always_ff @(posedge clk) begin
        key_d <= key_in;
        if (rst) begin
            state_q      <= EMPTY;
            evt_valid    <= 1'b0;
            evt_key      <= '0;
            ptr_q        <= KEY_W'(N_KEYS - 1);
            press_pend   <= '0;
            drop_cnt     <= '0;
            busy         <= 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
            release_pend <= '0;
            rel_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            evt_valid    <= evt_valid_d;
            evt_key      <= evt_key_d;
            ptr_q        <= ptr_d;
            press_pend   <= press_pend_n;
            drop_cnt     <= drop_cnt_d;
            busy         <= busy_d;
`ifdef KEY_RELEASE_EVENT_EN
            release_pend <= release_pend_n;
            rel_q        <= rel_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed scenarios plus random traffic, each cycle compared
// against a per-key pending-flag reference model.
module tb_key_event_scheduler;

    localparam int N  = 4;
    localparam int KW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  key_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_key;
    logic          evt_release;
    logic [7:0]    drop_cnt;
    logic          busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_kd [N];
    bit m_pp [N];
    bit m_rp [N];
    bit m_valid;
    bit m_rel;
    int m_key;
    int m_ptr;
    int m_drop;

    key_event_scheduler #(.N_KEYS(N), .KEY_W(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_key     (evt_key),
        .evt_release (evt_release),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int i = 0; i < N; i++) b = b | m_pp[i] | m_rp[i];
        return b;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] k, input bit rd);
        int g;
        bit gp;
        bit gr;
        int d;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_kd[i] = k[i];
                m_pp[i] = 0;
                m_rp[i] = 0;
            end
            m_valid = 0;
            m_key   = 0;
            m_rel   = 0;
            m_ptr   = N - 1;
            m_drop  = 0;
            return;
        end
        g  = -1;
        gp = 0;
        gr = 0;
        if (!m_valid || rd) begin
            for (int off = 1; off <= N; off++) begin
                int i = (m_ptr + off) % N;
                if (g < 0 && (m_pp[i] || m_rp[i])) g = i;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_key   = g;
                m_ptr   = g;
                if (m_pp[g]) begin gp = 1; m_rel = 0; end
                else begin gr = 1; m_rel = 1; end
            end else begin
                m_valid = 0;
            end
        end
        d = 0;
        for (int i = 0; i < N; i++) begin
            bit pe;
            bit re;
            pe = k[i] && !m_kd[i];
            re = !k[i] && m_kd[i];
            if (g == i && gp) m_pp[i] = 0;
            if (g == i && gr) m_rp[i] = 0;
            if (pe) begin
                if (m_pp[i]) d++;
                m_pp[i] = 1;
            end
`ifdef KEY_RELEASE_EVENT_EN
            if (re) begin
                if (m_rp[i]) d++;
                m_rp[i] = 1;
            end
`else
            if (re) d = d + 0;
`endif
            m_kd[i] = k[i];
        end
        m_drop = (m_drop + d > 255) ? 255 : m_drop + d;
    endtask

    task automatic step(input bit r, input logic [N-1:0] k, input bit rd);
        rst       = r;
        key_in    = k;
        evt_ready = rd;
        @(posedge clk);
        model_step(r, k, rd);
        #1;
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_key", 32'(evt_key), 32'(m_key));
        chk("evt_release", 32'(evt_release), 32'(m_rel));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("busy", 32'(busy), 32'(m_busy()));
    endtask

    task automatic drain(input logic [N-1:0] k);
        for (int i = 0; i < 50 && busy !== 1'b0; i++) step(0, k, 1);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        key_in    = '0;
        evt_ready = 1'b1;

        // Reset state
        step(1, 4'b0000, 1);
        step(1, 4'b0000, 1);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single press: pending after E, valid after E+1, for one cycle
        step(0, 4'b0000, 1);
        step(0, 4'b0001, 1);
        chk("single_E_valid", 32'(evt_valid), 32'd0);
        chk("single_E_busy", 32'(busy), 32'd1);
        step(0, 4'b0001, 1);
        chk("single_E1_valid", 32'(evt_valid), 32'd1);
        chk("single_E1_key", 32'(evt_key), 32'd0);
        chk("single_E1_rel", 32'(evt_release), 32'd0);
        step(0, 4'b0001, 1);
        chk("single_E2_valid", 32'(evt_valid), 32'd0);

        // Round robin from reset: 0,1,2,3 then idle
        step(1, 4'b0000, 1);
        step(0, 4'b1111, 1);
        for (int i = 0; i < N; i++) begin
            step(0, 4'b1111, 1);
            chk("rr_valid", 32'(evt_valid), 32'd1);
            chk("rr_key", 32'(evt_key), 32'(i));
        end
        step(0, 4'b1111, 1);
        chk("rr_end_valid", 32'(evt_valid), 32'd0);
        chk("rr_end_busy", 32'(busy), 32'd0);

        // Backpressure and drop on key 2
        step(1, 4'b0000, 0);
        step(0, 4'b0100, 0);
        step(0, 4'b0000, 0);
        step(0, 4'b0100, 0);
        step(0, 4'b0000, 0);
        step(0, 4'b0100, 0);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_key", 32'(evt_key), 32'd2);
`ifdef KEY_RELEASE_EVENT_EN
        chk("bp_drop", 32'(drop_cnt), 32'd2);
`else
        chk("bp_drop", 32'(drop_cnt), 32'd1);
`endif
        drain(4'b0100);

        // Drop counter saturation
        step(1, 4'b0000, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 4'b0010, 0);
            step(0, 4'b0000, 0);
        end
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        step(0, 4'b1111, 0);
        chk("sat_hold", 32'(drop_cnt), 32'd255);

        // Keys held through reset produce nothing
        step(1, 4'b1111, 1);
        step(1, 4'b1111, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1111, 1);
            chk("held_valid", 32'(evt_valid), 32'd0);
            chk("held_busy", 32'(busy), 32'd0);
        end

        // Reset during HOLD aborts the event
        step(1, 4'b0000, 0);
        step(0, 4'b0001, 0);
        step(0, 4'b0001, 0);
        chk("hold_valid", 32'(evt_valid), 32'd1);
        step(1, 4'b0001, 0);
        chk("hold_rst_valid", 32'(evt_valid), 32'd0);
        step(0, 4'b0001, 1);
        chk("hold_after_valid", 32'(evt_valid), 32'd0);

        // Press then release on key 1
        step(1, 4'b0000, 1);
        step(0, 4'b0010, 1);
        step(0, 4'b0000, 1);
        chk("pr_press_valid", 32'(evt_valid), 32'd1);
        chk("pr_press_key", 32'(evt_key), 32'd1);
        chk("pr_press_rel", 32'(evt_release), 32'd0);
        step(0, 4'b0000, 1);
`ifdef KEY_RELEASE_EVENT_EN
        chk("pr_rel_valid", 32'(evt_valid), 32'd1);
        chk("pr_rel_key", 32'(evt_key), 32'd1);
        chk("pr_rel_rel", 32'(evt_release), 32'd1);
`else
        chk("pr_rel_valid", 32'(evt_valid), 32'd0);
`endif
        drain(4'b0000);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit rd;
            logic [N-1:0] k;
            r  = ($urandom_range(0, 99) == 0);
            rd = ($urandom_range(0, 3) != 0);
            k  = N'($urandom);
            step(r, k, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of key requesters (2..8).
REQ-002 SHALL have parameter KEY_W, default 2, width of the key index (equals clog2(N_KEYS)).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_in  input  N_KEYS  level key states, already synchronized to clk.
REQ-006 SHALL have port evt_valid  output  1  event available on evt_key/evt_release.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts the event when evt_valid is 1.
REQ-008 SHALL have port evt_key  output  KEY_W  index of the key that produced the event.
REQ-009 SHALL have port evt_release  output  1  1 = release event, 0 = press event.
REQ-010 SHALL have port drop_cnt  output  8  saturating count of lost events.
REQ-011 SHALL have port busy  output  1  1 when evt_valid or any pending bit is set.

Function
REQ-012 SHALL register key_in per key into key_d; press edge = key_in & ~key_d, release edge = ~key_in & key_d.
REQ-013 SHALL set press_pend[i] on the edge where key i's press edge is true.
REQ-014 SHALL implement a two-state output FSM: EMPTY (evt_valid=0) and HOLD (evt_valid=1).
REQ-015 SHALL in EMPTY, or in HOLD with evt_ready=1, load the next event if any pending bit is set (-> HOLD), else go to EMPTY.
REQ-016 SHALL keep evt_valid, evt_key and evt_release stable in HOLD while evt_ready=0.
REQ-017 SHALL select the next key round-robin, searching from (last granted index + 1) mod N_KEYS upward with wrap; the pointer is updated only on a load.
REQ-018 SHALL clear the granted pending bit in the same edge the event is loaded.
REQ-019 SHALL, for key_in rising (key_d=0) at edge E with the FSM in EMPTY and no other pending bit set, set press_pend after E and assert evt_valid after E+1.
REQ-020 SHALL sustain one event per cycle when evt_ready is held at 1 and requests are pending.
REQ-021 SHALL, when a new edge arrives for a pending bit being granted in the same edge, leave the bit set; no drop is recorded.
REQ-022 SHALL, when a new edge arrives for a pending bit that is set and not granted that edge, record a drop and keep the bit set.
REQ-023 SHALL add the number of drops recorded in one edge to drop_cnt, saturating at 255.
REQ-024 SHALL drive evt_release=0 for every press event.

Reset
REQ-025 SHALL, while rst=1, clear all pending bits, evt_valid, evt_key, evt_release and drop_cnt, and set the round-robin pointer to N_KEYS-1 (key 0 is highest priority first).
REQ-026 SHALL load key_d from key_in while rst=1, so keys held through reset generate no event after release.
REQ-027 SHALL abort an in-flight HOLD event on reset with no completion handshake.

Configuration
REQ-028 SHALL honor macro KEY_RELEASE_EVENT_EN.
REQ-029 SHALL, with KEY_RELEASE_EVENT_EN defined, keep release_pend[i], set on release edges under REQ-021..023 drop rules.
REQ-030 SHALL, with KEY_RELEASE_EVENT_EN defined, treat key i as requesting if press_pend[i] or release_pend[i]; on grant, emit press if press_pend[i] is set, else release with evt_release=1.
REQ-031 SHALL, without KEY_RELEASE_EVENT_EN, ignore release edges, contain no release_pend state and tie evt_release to 0.

Verification
REQ-032 SHALL cover single press: key_in=0001 from reset, evt_ready=1 -> press_pend[0] after E, evt_valid=1, evt_key=0 after E+1, one cycle only.
REQ-033 SHALL cover round-robin: key_in 0000->1111 in one edge, evt_ready=1 -> evt_key 0,1,2,3 on consecutive cycles, then evt_valid=0.
REQ-034 SHALL cover backpressure and drop: evt_ready=0, key 2 pressed/released/pressed twice -> evt_key=2 held stable, drop_cnt=1; evt_ready=1 -> one event, busy=0.
REQ-035 SHALL cover saturation: 300 drop-causing presses with evt_ready=0 -> drop_cnt=255, no wrap.
REQ-036 SHALL cover reset: key_in=1111 held through rst, then rst=0 -> no event; rst asserted in HOLD -> evt_valid=0 next cycle.
REQ-037 SHALL cover KEY_RELEASE_EVENT_EN: key 1 press, then release, evt_ready=1 -> evt_key=1 with evt_release=0, then evt_key=1 with evt_release=1; without macro -> press event only.
